// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Multi-cycle sequencer for the LEGv8 datapath. Walks each instruction through
// FETCH, DECODE, EXEC, MEM and WB and drives every datapath control line from
// the current state and the registered instruction class. Instruction and data
// memories are variable latency (req/ready handshakes). Illegal opcodes and
// memory timeouts trap into a sticky ERR state that only reset leaves.
//
// Parameters:
//   MEM_TIMEOUT  max cycles waiting on a memory ready (0 disables the timeout)
//   CNT_W        width of the optional performance counters
//
// Optional feature (macro PERF_COUNT_EN):
//   Adds retired_cnt and stall_cnt outputs. Without the macro these ports and
//   their logic are absent.
//
// Ports:
//   CLK          in   clock, rising edge
//   reset        in   asynchronous active-high reset
//   run          in   1 permits fetching new instructions
//   opcode       in   instruction[31:21] from the instruction register
//   zero         in   ALU zero flag
//   imem_ready   in   instruction memory data valid
//   dmem_ready   in   data memory access complete
//   imem_req     out  instruction fetch request
//   dmem_req     out  data memory request
//   irwrite      out  load the instruction register
//   pcwrite      out  update the PC
//   pcsrc        out  0 = PC+4, 1 = PC+extimm
//   reg2loc      out  RB select (1 = instruction[4:0])
//   alusrc       out  ALU B source (1 = extimm)
//   mem2reg      out  write-back source (1 = memory)
//   regwrite     out  register file write enable
//   memread      out  data memory read
//   memwrite     out  data memory write
//   aluop        out  ALU control
//   signop       out  sign-extender control
//   state        out  current state (IDLE=0 .. ERR=6)
//   error        out  sticky trap flag
//   retired_cnt  out  instructions completed      (PERF_COUNT_EN only)
//   stall_cnt    out  memory wait cycles          (PERF_COUNT_EN only)
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             run,
    input  logic [10:0]      opcode,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             irwrite,
    output logic             pcwrite,
    output logic             pcsrc,
    output logic             reg2loc,
    output logic             alusrc,
    output logic             mem2reg,
    output logic             regwrite,
    output logic             memread,
    output logic             memwrite,
    output logic [3:0]       aluop,
    output logic [2:0]       signop,
    output logic [2:0]       state,
    output logic             error
`ifdef PERF_COUNT_EN
    ,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_NONE, C_ADD, C_SUB, C_AND, C_ORR,
        C_LDUR, C_STUR, C_CBZ, C_B, C_MOVZ, C_ILL
    } iclass_t;

    // The counter only ever needs to hold 0 .. MEM_TIMEOUT-1 before trapping.
    localparam int TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST =
        TMO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    state_t            state_q, state_d;
    iclass_t           class_q, dec_class;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              wait_low;
    logic              tmo_hit;
    logic              enter_wait;

    function automatic iclass_t decode_op(input logic [10:0] op);
        iclass_t c;
        casez (op)
            11'b10001011000: c = C_ADD;
            11'b11001011000: c = C_SUB;
            11'b10001010000: c = C_AND;
            11'b10101010000: c = C_ORR;
            11'b11111000010: c = C_LDUR;
            11'b11111000000: c = C_STUR;
            11'b10110100???: c = C_CBZ;
            11'b000101?????: c = C_B;
            11'b110100101??: c = C_MOVZ;
            default:         c = C_ILL;
        endcase
        return c;
    endfunction

    assign dec_class = decode_op(opcode);
    assign state     = state_q;

    // A memory is being waited on this cycle and has not answered.
    assign wait_low = ((state_q == S_FETCH) && !imem_ready) ||
                      ((state_q == S_MEM)   && !dmem_ready);

    // Checked only when ready is low, so a ready on the limit cycle wins.
    assign tmo_hit  = (MEM_TIMEOUT != 0) && (tmo_cnt == TMO_LAST);

    assign enter_wait = ((state_d == S_FETCH) && (state_q != S_FETCH)) ||
                        ((state_d == S_MEM)   && (state_q != S_MEM));

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            class_q <= C_NONE;
        end else if (state_q == S_DECODE) begin
            class_q <= dec_class;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (enter_wait) begin
            tmo_cnt <= '0;
        end else if (wait_low && !tmo_hit) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        irwrite  = 1'b0;
        pcwrite  = 1'b0;
        pcsrc    = 1'b0;
        reg2loc  = 1'b0;
        alusrc   = 1'b0;
        mem2reg  = 1'b0;
        regwrite = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        aluop    = 4'b0000;
        signop   = 3'b000;
        error    = 1'b0;

        // The datapath has no ALU output register, so the EXEC controls stay
        // applied through MEM and WB to keep the address / result valid.
        if ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)) begin
            case (class_q)
                C_ADD:  aluop = 4'b0010;
                C_SUB:  aluop = 4'b0110;
                C_AND:  aluop = 4'b0000;
                C_ORR:  aluop = 4'b0001;
                C_LDUR: begin aluop = 4'b0010; signop = 3'b001; alusrc = 1'b1; end
                C_STUR: begin
                    aluop = 4'b0010; signop = 3'b001; alusrc = 1'b1; reg2loc = 1'b1;
                end
                C_CBZ:  begin aluop = 4'b0111; signop = 3'b011; reg2loc = 1'b1; end
                C_B:    signop = 3'b010;
                C_MOVZ: begin aluop = 4'b0111; signop = 3'b100; alusrc = 1'b1; end
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    irwrite = 1'b1;
                    state_d = S_DECODE;
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                end
            end
            S_DECODE: begin
                state_d = (dec_class == C_ILL) ? S_ERR : S_EXEC;
            end
            S_EXEC: begin
                case (class_q)
                    C_ADD, C_SUB, C_AND, C_ORR, C_MOVZ: state_d = S_WB;
                    C_LDUR, C_STUR: state_d = S_MEM;
                    C_CBZ: begin
                        pcwrite = 1'b1;
                        pcsrc   = zero;
                        state_d = run ? S_FETCH : S_IDLE;
                    end
                    C_B: begin
                        pcwrite = 1'b1;
                        pcsrc   = 1'b1;
                        state_d = run ? S_FETCH : S_IDLE;
                    end
                    default: state_d = S_ERR;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                memread  = (class_q == C_LDUR);
                memwrite = (class_q == C_STUR);
                if (dmem_ready) begin
                    if (class_q == C_STUR) begin
                        pcwrite = 1'b1;
                        state_d = run ? S_FETCH : S_IDLE;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                end
            end
            S_WB: begin
                regwrite = 1'b1;
                mem2reg  = (class_q == C_LDUR);
                pcwrite  = 1'b1;
                state_d  = run ? S_FETCH : S_IDLE;
            end
            S_ERR: begin
                // Trap state: every datapath control is forced off.
                reg2loc = 1'b0;
                alusrc  = 1'b0;
                aluop   = 4'b0000;
                signop  = 3'b000;
                error   = 1'b1;
            end
            default: state_d = S_ERR;
        endcase
    end

`ifdef PERF_COUNT_EN
    // pcwrite pulses exactly once per instruction, on its completion cycle.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            retired_cnt <= '0;
            stall_cnt   <= '0;
        end else if (state_q != S_ERR) begin
            if (pcwrite)  retired_cnt <= retired_cnt + CNT_W'(1);
            if (wait_low) stall_cnt   <= stall_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
